// File: rtl/four_bit_down_counter.sv
// Loadable W-bit down counter with cascade borrow chain and selectable underflow
// behaviour (wrap, auto-reload from the last loaded value, or one-shot expire).
module four_bit_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         cen,
  input  logic         bi,
  input  logic [1:0]   md,
  input  logic [W-1:0] parIn,
  output logic [W-1:0] parOut,
  output logic         bo,
  output logic         tc,
  output logic         busy,
  output logic         exp
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state;
  logic [W-1:0] rld;
  logic         run;
  logic         dec;
  logic         zero;

  // Count value that follows an underflow; one-shot parks at zero.
  function automatic logic [W-1:0] underflow_value(input logic [1:0] m,
                                                   input logic [W-1:0] r);
    case (m)
      2'b01:   return r;
      2'b10:   return '0;
      default: return '1;
    endcase
  endfunction

  assign run  = (state == RUN);
  assign zero = (parOut == '0);
  assign dec  = run & cen & bi & ~ld;

  // Borrow-out deliberately ignores ld so a cascaded stage sees a stable enable.
  assign bo   = zero & cen & bi & run;
  assign busy = run;
  assign exp  = (state == EXPIRED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      parOut <= '0;
      rld    <= '0;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (ld) begin
        parOut <= parIn;
        rld    <= parIn;
        state  <= RUN;
      end else if (dec) begin
        if (!zero) begin
          parOut <= parOut - ONE;
        end else begin
          parOut <= underflow_value(md, rld);
          tc     <= 1'b1;
          if (md == 2'b10) state <= EXPIRED;
        end
      end
    end
  end

endmodule

// File: tb/tb_four_bit_down_counter.sv
// Self-checking bench: directed vector table, hand-written reset/chain sequences,
// and randomized traffic compared with a behavioural model.
module tb_four_bit_down_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld, cen, bi;
  logic [1:0] md;
  logic [3:0] parIn;
  logic [3:0] parOut;
  logic       bo, tc, busy, ex;

  logic       c_ld, c_cen, c_bi;
  logic [1:0] c_md;
  logic [7:0] c_pin;
  logic [3:0] lo_out, hi_out;
  logic       lo_bo, hi_bo, lo_tc, hi_tc, lo_busy, hi_busy, lo_exp, hi_exp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  four_bit_down_counter #(.W(4)) dut (
    .clk(clk), .rst(rst), .ld(ld), .cen(cen), .bi(bi), .md(md), .parIn(parIn),
    .parOut(parOut), .bo(bo), .tc(tc), .busy(busy), .exp(ex)
  );

  four_bit_down_counter #(.W(4)) lo (
    .clk(clk), .rst(rst), .ld(c_ld), .cen(c_cen), .bi(c_bi), .md(c_md), .parIn(c_pin[3:0]),
    .parOut(lo_out), .bo(lo_bo), .tc(lo_tc), .busy(lo_busy), .exp(lo_exp)
  );

  four_bit_down_counter #(.W(4)) hi (
    .clk(clk), .rst(rst), .ld(c_ld), .cen(c_cen), .bi(lo_bo), .md(c_md), .parIn(c_pin[7:4]),
    .parOut(hi_out), .bo(hi_bo), .tc(hi_tc), .busy(hi_busy), .exp(hi_exp)
  );

  typedef struct {
    logic       ld, cen, bi;
    logic [1:0] md;
    logic [3:0] pin;
    int         cnt;
    logic       tc, busy, ex, bo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic l, input logic c, input logic b, input logic [1:0] m,
                              input logic [3:0] p, input int n, input logic t, input logic bz,
                              input logic e, input logic o);
    vec_t v;
    v.ld = l; v.cen = c; v.bi = b; v.md = m; v.pin = p;
    v.cnt = n; v.tc = t; v.busy = bz; v.ex = e; v.bo = o;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " parOut"}, 32'(parOut), 0);
    check({tag, " busy"},   32'(busy),   0);
    check({tag, " tc"},     32'(tc),     0);
    check({tag, " exp"},    32'(ex),     0);
    check({tag, " bo"},     32'(bo),     0);
  endtask

  // Behavioural model: mode 0 = idle, 1 = running, 2 = expired.
  int m_cnt, m_rld, m_mode, m_tc;

  task automatic model_reset();
    m_cnt = 0; m_rld = 0; m_mode = 0; m_tc = 0;
  endtask

  task automatic model_step(input logic l, input logic c, input logic b,
                            input logic [1:0] m, input logic [3:0] p);
    m_tc = 0;
    if (l) begin
      m_cnt = p; m_rld = p; m_mode = 1;
    end else if (m_mode == 1 && c && b) begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else begin
        m_tc = 1;
        if (m == 2'd1)      m_cnt = m_rld;
        else if (m == 2'd2) m_mode = 2;
        else                m_cnt = 15;
      end
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ld = 0; cen = 0; bi = 0; md = 0; parIn = 0;
    c_ld = 0; c_cen = 0; c_bi = 1; c_md = 0; c_pin = 0;

    // Reset state
    #2;
    check_reset_outputs("por");
    edge_wait();
    rst = 1'b0;

    // Asynchronous reset in the middle of a count
    ld = 1; parIn = 4'h9; md = 0;
    edge_wait();
    ld = 0; cen = 1; bi = 1;
    check("load9 parOut", 32'(parOut), 32'h9);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midcount rst");
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      edge_wait();
      check("post-rst hold parOut", 32'(parOut), 0);
      check("post-rst hold busy",   32'(busy),   0);
    end

    // ld held during reset is ignored; first clean edge loads
    rst = 1'b1; ld = 1; parIn = 4'h6; cen = 0; bi = 0;
    edge_wait();
    check("ld under rst parOut", 32'(parOut), 0);
    rst = 1'b0;
    edge_wait();
    check("ld after rst parOut", 32'(parOut), 32'h6);
    check("ld after rst busy",   32'(busy),   1);

    // Directed vector table
    add(1, 0, 0, 0, 4'hB, 11, 0, 1, 0, 0);
    for (int k = 1; k <= 11; k++) add(0, 1, 1, 0, 0, 11 - k, 0, 1, 0, (k == 11));
    add(0, 1, 1, 0, 0, 15, 1, 1, 0, 0);
    add(0, 1, 1, 0, 0, 14, 0, 1, 0, 0);
    add(1, 0, 0, 1, 4'h3, 3, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 1, 1, 0, 3, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 1, 1, 0, 3, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 2, 0, 1, 0, 0);
    add(1, 0, 0, 2, 4'h2, 2, 0, 1, 0, 0);
    add(0, 1, 1, 2, 0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 2, 0, 0, 0, 1, 0, 1);
    add(0, 1, 1, 2, 0, 0, 1, 0, 1, 0);
    add(0, 1, 1, 2, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 2, 0, 0, 0, 0, 1, 0);
    add(1, 1, 1, 2, 4'h5, 5, 0, 1, 0, 0);
    add(1, 0, 0, 0, 4'h7, 7, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 7, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 7, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    add(1, 1, 1, 0, 4'h4, 4, 0, 1, 0, 0);
    add(1, 0, 0, 2, 4'h0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 2, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 4'h9, 9, 0, 1, 0, 0);
    add(1, 0, 0, 1, 4'h1, 1, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 1, 2, 0, 0, 1, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      ld = tbl[i].ld; cen = tbl[i].cen; bi = tbl[i].bi; md = tbl[i].md; parIn = tbl[i].pin;
      edge_wait();
      check($sformatf("vec%0d parOut", i), 32'(parOut), 32'(tbl[i].cnt));
      check($sformatf("vec%0d tc", i),     32'(tc),     32'(tbl[i].tc));
      check($sformatf("vec%0d busy", i),   32'(busy),   32'(tbl[i].busy));
      check($sformatf("vec%0d exp", i),    32'(ex),     32'(tbl[i].ex));
      check($sformatf("vec%0d bo", i),     32'(bo),     32'(tbl[i].bo));
    end

    // Two cascaded stages acting as an 8-bit counter
    c_ld = 1; c_pin = 8'h10; c_cen = 0; c_md = 0;
    edge_wait();
    check("chain load", 32'({hi_out, lo_out}), 32'h10);
    c_ld = 0; c_cen = 1;
    #1 check("chain lo.bo at 0", 32'(lo_bo), 1);
    edge_wait();
    check("chain 0x10-1", 32'({hi_out, lo_out}), 32'h0F);
    check("chain lo.bo at F", 32'(lo_bo), 0);
    c_ld = 1; c_pin = 8'h00; c_cen = 0;
    edge_wait();
    c_ld = 0; c_cen = 1;
    edge_wait();
    check("chain 0x00-1", 32'({hi_out, lo_out}), 32'hFF);
    begin
      int v;
      v = 8'hA3;
      c_ld = 1; c_pin = 8'hA3; c_cen = 0;
      edge_wait();
      c_ld = 0;
      for (int k = 0; k < 200; k++) begin
        c_cen = ($urandom_range(0, 3) != 0);
        edge_wait();
        if (c_cen) v = (v + 255) % 256;
        check("chain random", 32'({hi_out, lo_out}), 32'(v));
      end
    end
    c_cen = 0;

    // Randomized traffic against the model
    rst = 1'b1;
    edge_wait();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        #1 check_reset_outputs("rand rst");
        model_reset();
        edge_wait();
        rst = 1'b0;
      end else begin
        ld    = ($urandom_range(0, 9) == 0);
        cen   = ($urandom_range(0, 3) != 0);
        bi    = ($urandom_range(0, 4) != 0);
        md    = 2'($urandom_range(0, 3));
        parIn = 4'($urandom_range(0, 15));
        #1 check("rand bo", 32'(bo), 32'((m_cnt == 0) && cen && bi && (m_mode == 1)));
        model_step(ld, cen, bi, md, parIn);
        edge_wait();
        check("rand parOut", 32'(parOut), 32'(m_cnt));
        check("rand tc",     32'(tc),     32'(m_tc));
        check("rand busy",   32'(busy),   32'(m_mode == 1));
        check("rand exp",    32'(ex),     32'(m_mode == 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
